trace_buffer: RTL and testbench

Capture FIFO that sits directly downstream of the single-cycle processor's trace port (`trace_val`/`trace_addr`/`trace_data`). It records every retired-instruction trace record, tags each one with a sequence number, and drains the records through a val/rdy stream to a slower consumer such as a host link or a checker. Overflow is never silent: dropped records are counted, and the sequence gaps remain visible to the consumer.

---
 rtl/trace_buffer.sv | 124 ++++++++++++
 tb/tb_trace_buffer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/trace_buffer.sv
`default_nettype none
//============================================================================
// Module   : trace_buffer
// Purpose  : Capture FIFO for a processor trace port. Every retired
//            instruction record is tagged with a running sequence number.
//            Records drain through a val/rdy stream. When the FIFO is full,
//            records are dropped, counted and flagged. The sequence number
//            still advances on a drop, so the consumer sees a gap.
// Ports    : clk, rst (async, active-high)
//            trace_val/trace_addr/trace_data - incoming trace records
//            clear                           - synchronous flush
//            drain_val/drain_rdy             - head-of-queue handshake
//            drain_seq/drain_addr/drain_data - head record fields
//            count                           - occupancy
//            overflow/drop_count             - drop reporting
// Revision : 1.0 - initial release
//============================================================================
module trace_buffer #(
    parameter int DEPTH = 8,
    parameter int SEQW  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trace_val,
    input  logic [31:0]              trace_addr,
    input  logic [31:0]              trace_data,
    input  logic                     clear,
    output logic                     drain_val,
    input  logic                     drain_rdy,
    output logic [SEQW-1:0]          drain_seq,
    output logic [31:0]              drain_addr,
    output logic [31:0]              drain_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [SEQW-1:0]          drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Storage is deliberately not reset.
    logic [SEQW-1:0] r_mem_seq  [DEPTH];
    logic [31:0]     r_mem_addr [DEPTH];
    logic [31:0]     r_mem_data [DEPTH];

    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [SEQW-1:0] r_seq;
    logic            r_overflow;
    logic [SEQW-1:0] r_drop_count;

    logic w_full;
    logic w_deq;
    logic w_enq;
    logic w_drop;

    // clear masks every event that cycle, including a dequeue.
    assign w_full = (r_count == CW'(DEPTH));
    assign w_deq  = (r_count != '0) && drain_rdy && !clear;
    // When full, a same-cycle dequeue frees the slot being written.
    assign w_enq  = trace_val && !clear && (!w_full || w_deq);
    assign w_drop = trace_val && !clear && w_full && !w_deq;

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem_seq[r_wr_ptr]  <= r_seq;
            r_mem_addr[r_wr_ptr] <= trace_addr;
            r_mem_data[r_wr_ptr] <= trace_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_seq        <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (clear) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_seq        <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            // Sequence advances on stored and dropped records alike.
            if (trace_val) begin
                r_seq <= r_seq + SEQW'(1);
            end
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != '1) begin
                    r_drop_count <= r_drop_count + SEQW'(1);
                end
            end
        end
    end

    // Head fields come straight from storage at the read pointer. When the
    // queue is empty they show the stale head-slot contents.
    assign drain_val  = (r_count != '0);
    assign drain_seq  = r_mem_seq[r_rd_ptr];
    assign drain_addr = r_mem_addr[r_rd_ptr];
    assign drain_data = r_mem_data[r_rd_ptr];
    assign count      = r_count;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_trace_buffer.sv
`default_nettype none
//============================================================================
// Module   : tb_trace_buffer
// Purpose  : Directed self-checking bench for trace_buffer (DEPTH=8,
//            SEQW=16) with hand-computed expected values.
// Revision : 1.0 - initial release
//============================================================================
module tb_trace_buffer;

    logic        clk;
    logic        rst;
    logic        trace_val;
    logic [31:0] trace_addr;
    logic [31:0] trace_data;
    logic        clear;
    logic        drain_val;
    logic        drain_rdy;
    logic [15:0] drain_seq;
    logic [31:0] drain_addr;
    logic [31:0] drain_data;
    logic [3:0]  count;
    logic        overflow;
    logic [15:0] drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    trace_buffer #(
        .DEPTH (8),
        .SEQW  (16)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .trace_val  (trace_val),
        .trace_addr (trace_addr),
        .trace_data (trace_data),
        .clear      (clear),
        .drain_val  (drain_val),
        .drain_rdy  (drain_rdy),
        .drain_seq  (drain_seq),
        .drain_addr (drain_addr),
        .drain_data (drain_data),
        .count      (count),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        trace_val  = 1'b1;
        trace_addr = a;
        trace_data = d;
        step();
        trace_val  = 1'b0;
    endtask

    initial begin
        int exp_seq [8];

        rst        = 1'b1;
        clear      = 1'b0;
        trace_val  = 1'b0;
        trace_addr = '0;
        trace_data = '0;
        drain_rdy  = 1'b0;

        // Reset then idle
        step();
        step();
        rst = 1'b0;
        repeat (5) step();
        chk("rst_drain_val", 64'(drain_val), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_drop_count", 64'(drop_count), 64'd0);

        // Single record
        push(32'h0000_0000, 32'h0000_0002);
        chk("single_val", 64'(drain_val), 64'd1);
        chk("single_seq", 64'(drain_seq), 64'd0);
        chk("single_addr", 64'(drain_addr), 64'h0);
        chk("single_data", 64'(drain_data), 64'h2);
        chk("single_count", 64'(count), 64'd1);
        drain_rdy = 1'b1;
        step();
        drain_rdy = 1'b0;
        chk("single_count_after", 64'(count), 64'd0);
        chk("single_val_after", 64'(drain_val), 64'd0);

        // Streaming: 20 records with drain_rdy held high
        clear = 1'b1;
        step();
        clear = 1'b0;
        drain_rdy  = 1'b1;
        trace_val  = 1'b1;
        trace_addr = 32'h0;
        trace_data = 32'h0;
        step();
        for (int i = 0; i < 20; i++) begin
            chk("stream_val", 64'(drain_val), 64'd1);
            chk("stream_seq", 64'(drain_seq), 64'(i));
            chk("stream_addr", 64'(drain_addr), 64'(4 * i));
            chk("stream_data", 64'(drain_data), 64'(i));
            chk("stream_count", 64'(count), 64'd1);
            trace_val  = (i + 1 < 20);
            trace_addr = 32'(4 * (i + 1));
            trace_data = 32'(i + 1);
            step();
        end
        trace_val = 1'b0;
        drain_rdy = 1'b0;
        chk("stream_end_count", 64'(count), 64'd0);
        chk("stream_overflow", 64'(overflow), 64'd0);

        // Overflow: 11 records into 8 slots, no draining
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 11; i++) begin
            push(32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
            chk("ovf_fill_count", 64'(count), 64'((i < 8) ? i + 1 : 8));
        end
        chk("ovf_count", 64'(count), 64'd8);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_drops", 64'(drop_count), 64'd3);
        chk("ovf_head_seq", 64'(drain_seq), 64'd0);

        // Full + simultaneous enqueue/dequeue: new record gets seq 11
        trace_val  = 1'b1;
        trace_addr = 32'h100 + 32'(4 * 11);
        trace_data = 32'hAB;
        drain_rdy  = 1'b1;
        step();
        trace_val = 1'b0;
        drain_rdy = 1'b0;
        chk("full_sim_count", 64'(count), 64'd8);
        chk("full_sim_drops", 64'(drop_count), 64'd3);
        chk("full_sim_head", 64'(drain_seq), 64'd1);

        // Drain everything: seq 1..7 then 11
        exp_seq = '{1, 2, 3, 4, 5, 6, 7, 11};
        drain_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("drain_val", 64'(drain_val), 64'd1);
            chk("drain_seq", 64'(drain_seq), 64'(exp_seq[k]));
            chk("drain_addr", 64'(drain_addr), 64'(32'h100 + 32'(4 * exp_seq[k])));
            step();
        end
        drain_rdy = 1'b0;
        chk("drain_empty_count", 64'(count), 64'd0);
        chk("drain_ovf_sticky", 64'(overflow), 64'd1);
        chk("drain_drops_kept", 64'(drop_count), 64'd3);

        // Clear versus concurrent traffic
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_ovf", 64'(overflow), 64'd0);
        chk("clear_drops", 64'(drop_count), 64'd0);
        for (int i = 0; i < 3; i++) begin
            push(32'h200 + 32'(i), 32'h300 + 32'(i));
        end
        chk("clr_pre_count", 64'(count), 64'd3);
        clear      = 1'b1;
        trace_val  = 1'b1;
        trace_addr = 32'hDEAD;
        drain_rdy  = 1'b1;
        step();
        clear     = 1'b0;
        trace_val = 1'b0;
        drain_rdy = 1'b0;
        chk("clr_count", 64'(count), 64'd0);
        chk("clr_val", 64'(drain_val), 64'd0);
        push(32'h55, 32'h66);
        chk("clr_next_val", 64'(drain_val), 64'd1);
        chk("clr_next_seq", 64'(drain_seq), 64'd0);
        chk("clr_next_addr", 64'(drain_addr), 64'h55);

        // Async reset mid-drain
        for (int i = 0; i < 5; i++) begin
            push(32'h400 + 32'(i), 32'h0);
        end
        chk("arst_pre6", 64'(count), 64'd6);
        drain_rdy = 1'b1;
        step();
        chk("arst_pre5", 64'(count), 64'd5);
        #3 rst = 1'b1;
        #1;
        chk("arst_val", 64'(drain_val), 64'd0);
        chk("arst_count", 64'(count), 64'd0);
        #1 rst = 1'b0;
        drain_rdy = 1'b0;
        step();
        push(32'h77, 32'h88);
        chk("arst_next_seq", 64'(drain_seq), 64'd0);
        chk("arst_next_count", 64'(count), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
